// File: rtl/rst_seq.sv
// rst_seq: reset sequencer and request qualifier for the complex multiplier core.
// Filters a raw reset request, stretches it into a core reset of fixed length,
// holds off 'done' for a settle window after release, and counts accepted and
// rejected (too short) requests with saturating counters.
module rst_seq #(
  parameter int FILT      = 3,
  parameter int HOLD      = 4,
  parameter int WAIT_DONE = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  output logic             core_rst_o,
  output logic             done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] rst_cnt_o,
  output logic [CNT_W-1:0] glitch_cnt_o
);

  // The shared cycle counter must hold the largest terminal count of the three phases.
  localparam int MAX_A = (FILT > HOLD) ? FILT : HOLD;
  localparam int MAX_C = (MAX_A > WAIT_DONE) ? MAX_A : WAIT_DONE;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_DONE - 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_QUAL    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             core_rst_q, core_rst_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1'b1);
    end
    return r;
  endfunction

  // Next-state, counter and arming logic; outputs are decoded from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst_cnt_d    = rst_cnt_q;
    glitch_cnt_d = glitch_cnt_q;
    // A low sample re-arms the qualifier; acceptance (below) only happens with req high.
    if (!req_i) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (armed_q && req_i) begin
          if (FILT == 1) begin
            state_d   = S_HOLD;
            cnt_d     = CNT_ZERO;
            rst_cnt_d = sat_inc(rst_cnt_q);
            armed_d   = 1'b0;
          end else begin
            state_d = S_QUAL;
            cnt_d   = CNT_ONE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_QUAL: begin
        if (!req_i) begin
          state_d      = S_RUN;
          cnt_d        = CNT_ZERO;
          glitch_cnt_d = sat_inc(glitch_cnt_q);
        end else if (cnt_q == FILT_LAST) begin
          state_d   = S_HOLD;
          cnt_d     = CNT_ZERO;
          rst_cnt_d = sat_inc(rst_cnt_q);
          armed_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = CNT_ZERO;
      end
    endcase

    core_rst_d = (state_d == S_HOLD);
    done_d     = (state_d == S_RUN) || (state_d == S_QUAL);
    busy_d     = (state_d != S_RUN);
  end

  // State, counters and registered outputs; rst forces the power-on hold phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HOLD;
      cnt_q        <= CNT_ZERO;
      armed_q      <= 1'b0;
      core_rst_q   <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
      rst_cnt_q    <= {CNT_W{1'b0}};
      glitch_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      core_rst_q   <= core_rst_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      rst_cnt_q    <= rst_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign core_rst_o   = core_rst_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign rst_cnt_o    = rst_cnt_q;
  assign glitch_cnt_o = glitch_cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: vector table with expected-output scoreboard for the default
// configuration, plus short hand-written sequences for a 2-bit counter build
// and the all-ones timing build.
module tb_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration (FILT=3, HOLD=4, WAIT_DONE=2, CNT_W=8)
  logic       rst_a = 1'b1, req_a = 1'b0;
  logic       core_a, done_a, busy_a;
  logic [7:0] rc_a, gc_a;

  // Narrow counters (CNT_W=2)
  logic       rst_b = 1'b1, req_b = 1'b0;
  logic       core_b, done_b, busy_b;
  logic [1:0] rc_b, gc_b;

  // Minimal timing (FILT=HOLD=WAIT_DONE=1)
  logic       rst_c = 1'b1, req_c = 1'b0;
  logic       core_c, done_c, busy_c;
  logic [7:0] rc_c, gc_c;

  rst_seq u_dut_a (
    .clk(clk), .rst(rst_a), .req_i(req_a),
    .core_rst_o(core_a), .done_o(done_a), .busy_o(busy_a),
    .rst_cnt_o(rc_a), .glitch_cnt_o(gc_a)
  );

  rst_seq #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .req_i(req_b),
    .core_rst_o(core_b), .done_o(done_b), .busy_o(busy_b),
    .rst_cnt_o(rc_b), .glitch_cnt_o(gc_b)
  );

  rst_seq #(.FILT(1), .HOLD(1), .WAIT_DONE(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .req_i(req_c),
    .core_rst_o(core_c), .done_o(done_c), .busy_o(busy_c),
    .rst_cnt_o(rc_c), .glitch_cnt_o(gc_c)
  );

  typedef struct packed {
    logic       core;
    logic       done;
    logic       busy;
    logic [7:0] rc;
    logic [7:0] gc;
  } out_t;

  typedef struct {
    string tag;
    logic  rst;
    logic  req;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic add(input string tag, input logic r, input logic q,
                     input logic c, input logic d, input logic b,
                     input int rc, input int gc, input int n);
    vec_t v;
    v.tag = tag;
    v.rst = r;
    v.req = q;
    v.exp = {c, d, b, rc[7:0], gc[7:0]};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t act, e;

    // ---------------- table for the default build ----------------
    // power-on: rst 3 cycles, core reset falls at E3, done at E5
    add("por_rst",     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 3);
    add("por_hold",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 3);
    add("por_rel",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    add("por_run",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2);
    // accepted request: 3 high samples
    add("acc_qual",    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1 - 1, 0, 2);
    add("acc_fire",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1);
    add("acc_hold",    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 3);
    add("acc_rel",     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2);
    add("acc_run",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 2);
    // five 2-cycle glitches
    for (int g = 1; g <= 5; g++) begin
      add("glt_qual",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, g - 1, 2);
      add("glt_drop",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, g, 1);
    end
    // request held for 40 cycles: one event only
    add("held_qual",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 5, 2);
    add("held_fire",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 5, 1);
    add("held_hold",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 5, 3);
    add("held_rel",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 5, 2);
    add("held_run",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 5, 32);
    // one low cycle re-arms, then 3 high samples are accepted
    add("held_low",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5, 1);
    add("rearm_qual",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 5, 2);
    add("rearm_fire",  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 5, 1);
    add("rearm_hold",  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 5, 3);
    add("rearm_rel",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 5, 1);
    // rst asserted during RELEASE, power-on repeats
    add("mid_rel_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1);
    add("por2_hold",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 3);
    add("por2_rel",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    add("por2_run",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1);
    // rst asserted during QUAL with req still high
    add("mid_q_qual",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1);
    add("mid_q_rst",   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1);
    // req high out of reset is ignored until seen low
    add("por3_hold",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 3);
    add("por3_rel",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 2);
    add("por3_unarm",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 4);
    add("por3_low",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1);
    add("por3_qual",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 2);
    add("por3_fire",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1);
    add("por3_hold2",  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 3);
    add("por3_rel2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2);
    add("por3_run",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1);

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst;
      req_a = tbl[i].req;
      exp_q.push_back(tbl[i].exp);
      tick();
      act = {core_a, done_a, busy_a, rc_a, gc_a};
      e   = exp_q.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s[%0d]: got core=%b done=%b busy=%b rst_cnt=%0d glitch_cnt=%0d, expected core=%b done=%b busy=%b rst_cnt=%0d glitch_cnt=%0d",
                 tbl[i].tag, i, act.core, act.done, act.busy, act.rc, act.gc,
                 e.core, e.done, e.busy, e.rc, e.gc);
      end
    end

    // ---------------- CNT_W=2: glitch counter saturates at 3 ----------------
    rst_b = 1'b0;
    req_b = 1'b0;
    repeat (6) tick();
    chk("b_por_done", int'(done_b), 1);
    chk("b_por_busy", int'(busy_b), 0);
    for (int g = 1; g <= 6; g++) begin
      req_b = 1'b1;
      repeat (2) tick();
      req_b = 1'b0;
      tick();
      chk("b_glitch_cnt", int'(gc_b), (g < 3) ? g : 3);
    end
    chk("b_core", int'(core_b), 0);
    chk("b_done", int'(done_b), 1);
    chk("b_rst_cnt", int'(rc_b), 0);

    // ---------------- FILT=HOLD=WAIT_DONE=1: single-cycle pulse ----------------
    rst_c = 1'b0;
    req_c = 1'b0;
    tick();
    chk("c_por_core", int'(core_c), 0);
    chk("c_por_done", int'(done_c), 0);
    tick();
    chk("c_run_done", int'(done_c), 1);
    chk("c_run_busy", int'(busy_c), 0);
    req_c = 1'b1;
    tick();
    chk("c_fire_core", int'(core_c), 1);
    chk("c_fire_done", int'(done_c), 0);
    chk("c_fire_cnt", int'(rc_c), 1);
    req_c = 1'b0;
    tick();
    chk("c_rel_core", int'(core_c), 0);
    chk("c_rel_done", int'(done_c), 0);
    tick();
    chk("c_back_core", int'(core_c), 0);
    chk("c_back_done", int'(done_c), 1);
    tick();
    chk("c_idle_done", int'(done_c), 1);
    chk("c_idle_rcnt", int'(rc_c), 1);
    chk("c_idle_gcnt", int'(gc_c), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
